// File: rtl/decimating_averager.sv
`default_nettype none
// ============================================================================
// Module  : decimating_averager
// Purpose : Block mean over 2^L valid samples (round half up), 2-entry output FIFO.
// Revision: 1.0
// ============================================================================
module decimating_averager #(
  parameter int IN_BITS  = 16,
  parameter int MAX_LOG2 = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_BITS-1:0] in_data,
  input  logic               in_valid,
  input  logic [4:0]         log2_len,
  output logic [IN_BITS-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun,
  output logic [15:0]        drop_count,
  output logic               busy
);

  localparam int ACC_W = IN_BITS + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam logic [4:0] MAX_LEN = 5'(MAX_LOG2);

  // Accumulation stage
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        sample_count;
  logic [4:0]              len_latched;

  logic [4:0]              len_clamped;
  logic [4:0]              len_cur;
  logic [CNT_W-1:0]        count_last;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    window_close;

  // Closed-window sum waiting for rounding
  logic                    close_valid;
  logic signed [ACC_W-1:0] close_sum;
  logic [4:0]              close_len;

  // Rounded result stage
  logic                    pipe_valid;
  logic [IN_BITS-1:0]      pipe_data;

  logic signed [ACC_W:0]   round_half;
  logic signed [ACC_W:0]   round_sum;
  logic signed [ACC_W:0]   round_shifted;
  logic [IN_BITS-1:0]      round_result;
  logic                    unused_round_bits;

  // Output FIFO
  logic [IN_BITS-1:0]      fifo_mem [2];
  logic                    rd_ptr;
  logic                    wr_ptr;
  logic [1:0]              fifo_count;
  logic                    fifo_full;
  logic                    fifo_pop;
  logic                    fifo_push;
  logic                    fifo_drop;

  // The window length is taken from the port only on the first sample of a window.
  assign len_clamped  = (log2_len > MAX_LEN) ? MAX_LEN : log2_len;
  assign len_cur      = (sample_count == '0) ? len_clamped : len_latched;
  assign count_last   = (CNT_W'(1) << len_cur) - CNT_W'(1);
  assign sample_ext   = {{MAX_LOG2{in_data[IN_BITS-1]}}, in_data};
  assign acc_sum      = acc + sample_ext;
  assign window_close = (sample_count == count_last);
  assign busy         = (sample_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      sample_count <= '0;
      len_latched  <= '0;
      close_valid  <= 1'b0;
      close_sum    <= '0;
      close_len    <= '0;
    end else begin
      close_valid <= 1'b0;
      if (in_valid) begin
        if (window_close) begin
          close_valid  <= 1'b1;
          close_sum    <= acc_sum;
          close_len    <= len_cur;
          acc          <= '0;
          sample_count <= '0;
        end else begin
          acc          <= acc_sum;
          sample_count <= sample_count + CNT_W'(1);
          len_latched  <= len_cur;
        end
      end
    end
  end

  // One extra guard bit keeps sum + half from wrapping before the shift.
  assign round_half    = (close_len == 5'd0) ? '0
                       : ((ACC_W+1)'(1) << (close_len - 5'd1));
  assign round_sum     = {close_sum[ACC_W-1], close_sum} + round_half;
  assign round_shifted = round_sum >>> close_len;
  assign round_result  = round_shifted[IN_BITS-1:0];
  assign unused_round_bits = ^round_shifted[ACC_W:IN_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= close_valid;
      if (close_valid) begin
        pipe_data <= round_result;
      end
    end
  end

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign fifo_full = (fifo_count == 2'd2);
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_push = pipe_valid && (!fifo_full || fifo_pop);
  assign fifo_drop = pipe_valid && fifo_full && !fifo_pop;

  // On a full FIFO with a pop, the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr] <= pipe_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (fifo_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (fifo_drop) begin
      overrun <= 1'b1;
      if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/decimating_averager.md
DECIMATING_AVERAGER -- requirements
Module: decimating_averager

Interface
REQ-001 SHALL provide parameter IN_BITS, default 16, meaning the width of signed two's-complement input and output samples.
REQ-002 SHALL provide parameter MAX_LOG2, default 16, meaning the largest supported log2 window length.
REQ-003 SHALL provide port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL provide port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port in_data  input  IN_BITS  signed sample (e.g. demodulator/IIR output).
REQ-006 SHALL provide port in_valid  input  1  in_data qualifies this cycle; no backpressure on input.
REQ-007 SHALL provide port log2_len  input  5  log2 of window length L.
REQ-008 SHALL provide port out_data  output  IN_BITS  signed window mean, head of output buffer.
REQ-009 SHALL provide port out_valid  output  1  out_data holds a result.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
REQ-011 SHALL provide port overrun  output  1  sticky flag; a result was dropped.
REQ-012 SHALL provide port drop_count  output  16  number of dropped results, saturating.
REQ-013 SHALL provide port busy  output  1  a window is partially accumulated (sample count nonzero).

Function
REQ-014 SHALL clamp effective L to MAX_LOG2 when log2_len > MAX_LOG2.
REQ-015 SHALL latch L on the first valid sample of each window; log2_len changes mid-window take effect only at the next window.
REQ-016 SHALL accumulate sign-extended in_data in an accumulator IN_BITS+MAX_LOG2 bits wide; no overflow possible.
REQ-017 SHALL count valid samples; a window closes on the 2^L-th valid sample; cycles with in_valid low hold all state.
REQ-018 SHALL compute the result as floor((sum + 2^(L-1)) / 2^L) via an arithmetic right shift (round half up); for L=0, the result is the sample itself.
REQ-019 SHALL register the rounded result in one pipeline stage; for a closing sample taken on edge k, out_valid is high after edge k+2 when the buffer is empty.
REQ-020 SHALL restart accumulation at the sample after the closing one, with no lost or duplicated samples between windows.
REQ-021 SHALL hold results in a 2-entry FIFO; out_data/out_valid reflect the head; a pop occurs on out_valid & out_ready.
REQ-022 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-023 SHALL, when the pipeline result arrives with the FIFO full and no pop in that cycle, drop the new result, set overrun, and increment drop_count (saturating at 0xFFFF).
REQ-024 SHALL, when a push and a pop coincide on a full FIFO, perform both with no drop.
REQ-025 SHALL support back-to-back windows at L=0 (one result per valid cycle) at full rate while out_ready is held high.

Reset
REQ-026 SHALL, on reset, clear the accumulator, sample count, latched L, pipeline stage and FIFO; out_valid=0, out_data=0, overrun=0, drop_count=0, busy=0.
REQ-027 SHALL discard a partially accumulated window and any in-flight result when reset is asserted mid-window; the first valid sample after reset starts a new window.
REQ-028 SHALL ignore in_valid during reset cycles.

Verification
REQ-029 SHALL verify: L=2, out_ready=1, valid samples 1,2,3,4 -> one result 3 (10+2>>2), out_valid one cycle, exactly 2 cycles after the 4th sample.
REQ-030 SHALL verify: L=1, samples -3,-4 -> result -3 (floor((-7+1)/2)); samples -32768,-32768 -> -32768.
REQ-031 SHALL verify: L=0, out_ready=0, 4 consecutive valid samples 5,6,7,8 -> FIFO holds 5,6; drop_count=2, overrun=1; raising out_ready pops 5 then 6.
REQ-032 SHALL verify: L=3, with log2_len changed to 1 after the 2nd sample -> first window still closes after 8 samples; next window closes after 2.
REQ-033 SHALL verify: reset asserted after 3 of 4 samples (L=2), then samples 8,8,8,8 -> single result 8, busy=0 right after reset, no stale output.
REQ-034 SHALL verify: FIFO full with out_ready=1 on the push cycle -> no drop; drop_count unchanged; order preserved.
